// File: rtl/vga_frame_loader_if.sv
// vga_frame_loader_if
// Groups the byte stream, paint request, BRAM write port and load status
// signals of the frame loader into one bundle.
//   rx_data/rx_valid          : bytes from the UART receiver
//   paint_req/x/y/color/ack   : single-pixel paint request and its acknowledge
//   bram_addr/din/we          : frame-buffer write port (one RGB111 byte per pixel)
//   loading/load_done/load_error/pixel_count : load progress and status
// master : the surrounding system (UART, cursor logic, BRAM, status readers)
// slave  : the frame loader itself
interface vga_frame_loader_if;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        paint_req;
  logic [9:0]  paint_x;
  logic [9:0]  paint_y;
  logic [2:0]  paint_color;
  logic        paint_ack;
  logic [18:0] bram_addr;
  logic [7:0]  bram_din;
  logic        bram_we;
  logic        loading;
  logic        load_done;
  logic        load_error;
  logic [18:0] pixel_count;

  modport master (
    output rx_data, rx_valid, paint_req, paint_x, paint_y, paint_color,
    input  paint_ack, bram_addr, bram_din, bram_we,
    input  loading, load_done, load_error, pixel_count
  );

  modport slave (
    input  rx_data, rx_valid, paint_req, paint_x, paint_y, paint_color,
    output paint_ack, bram_addr, bram_din, bram_we,
    output loading, load_done, load_error, pixel_count
  );
endinterface

// File: rtl/vga_frame_loader.sv
// vga_frame_loader
// Write side of the VGA frame buffer. A frame arrives over the UART as the
// header SYNC0,SYNC1 followed by H_RES*V_RES pixel bytes (low 3 bits = RGB),
// written to linear addresses 0..H_RES*V_RES-1. While idle, single-pixel
// paint requests are written at y*H_RES+x. A silent UART during a load
// aborts it and raises a sticky load_error.
// Ports:
//   clk_50mhz : system clock
//   reset     : asynchronous, active-high reset
//   bus       : vga_frame_loader_if.slave (UART bytes, paint request/ack,
//               BRAM write port, loading/load_done/load_error/pixel_count)
// All outputs are registered.
module vga_frame_loader #(
  parameter int          H_RES          = 640,
  parameter int          V_RES          = 480,
  parameter logic [7:0]  SYNC0          = 8'hAA,
  parameter logic [7:0]  SYNC1          = 8'h55,
  parameter int          TIMEOUT_CYCLES = 50_000_000
) (
  input logic               clk_50mhz,
  input logic               reset,
  vga_frame_loader_if.slave bus
);

  localparam int                CNT_W      = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0]  TO_LAST    = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [18:0]       LAST_PIXEL = 19'(H_RES * V_RES - 1);
  localparam logic [9:0]        X_LIM      = 10'(H_RES);
  localparam logic [9:0]        Y_LIM      = 10'(V_RES);

  typedef enum logic [1:0] {IDLE, SYNC1_WAIT, LOAD, DONE} state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  timeout_q, timeout_d;
  logic [18:0]       pixel_count_q, pixel_count_d;
  logic              load_error_q, load_error_d;
  logic              loading_q, loading_d;
  logic              load_done_q, load_done_d;
  logic              paint_ack_q, paint_ack_d;
  logic              paint_pend_q, paint_pend_d;
  logic [18:0]       paint_addr_q, paint_addr_d;
  logic [2:0]        paint_rgb_q, paint_rgb_d;
  logic              bram_we_q, bram_we_d;
  logic [18:0]       bram_addr_q, bram_addr_d;
  logic [7:0]        bram_din_q, bram_din_d;

  logic [18:0]       paint_lin;
  logic              paint_in_range;

  // For H_RES=640 the constant multiply reduces to (y<<9)+(y<<7)+x.
  assign paint_lin      = 19'(bus.paint_y) * 19'(H_RES) + 19'(bus.paint_x);
  assign paint_in_range = (bus.paint_x < X_LIM) && (bus.paint_y < Y_LIM);

  // State and output registers.
  always_ff @(posedge clk_50mhz or posedge reset) begin
    if (reset) begin
      state_q       <= IDLE;
      timeout_q     <= '0;
      pixel_count_q <= '0;
      load_error_q  <= 1'b0;
      loading_q     <= 1'b0;
      load_done_q   <= 1'b0;
      paint_ack_q   <= 1'b0;
      paint_pend_q  <= 1'b0;
      paint_addr_q  <= '0;
      paint_rgb_q   <= '0;
      bram_we_q     <= 1'b0;
      bram_addr_q   <= '0;
      bram_din_q    <= '0;
    end else begin
      state_q       <= state_d;
      timeout_q     <= timeout_d;
      pixel_count_q <= pixel_count_d;
      load_error_q  <= load_error_d;
      loading_q     <= loading_d;
      load_done_q   <= load_done_d;
      paint_ack_q   <= paint_ack_d;
      paint_pend_q  <= paint_pend_d;
      paint_addr_q  <= paint_addr_d;
      paint_rgb_q   <= paint_rgb_d;
      bram_we_q     <= bram_we_d;
      bram_addr_q   <= bram_addr_d;
      bram_din_q    <= bram_din_d;
    end
  end

  // Next-state and output logic. loading/load_done follow the state one
  // cycle late, so load_done lines up with loading falling, one cycle after
  // the last pixel write. A paint is acked first and written the cycle after
  // the ack; that write can never meet a LOAD write because LOAD is at least
  // two states away from the IDLE cycle that accepted the paint.
  always_comb begin
    state_d       = state_q;
    timeout_d     = timeout_q;
    pixel_count_d = pixel_count_q;
    load_error_d  = load_error_q;
    loading_d     = (state_q == SYNC1_WAIT) || (state_q == LOAD);
    load_done_d   = (state_q == DONE);
    paint_ack_d   = 1'b0;
    paint_pend_d  = 1'b0;
    paint_addr_d  = paint_addr_q;
    paint_rgb_d   = paint_rgb_q;
    bram_we_d     = 1'b0;
    bram_addr_d   = bram_addr_q;
    bram_din_d    = bram_din_q;

    if (paint_pend_q) begin
      bram_we_d   = 1'b1;
      bram_addr_d = paint_addr_q;
      bram_din_d  = {5'b0, paint_rgb_q};
    end

    case (state_q)
      IDLE: begin
        timeout_d = '0;
        if (bus.rx_valid && (bus.rx_data == SYNC0)) begin
          state_d      = SYNC1_WAIT;
          load_error_d = 1'b0;
        end
        if (bus.paint_req && !paint_ack_q) begin
          paint_ack_d  = 1'b1;
          paint_pend_d = paint_in_range;
          paint_addr_d = paint_lin;
          paint_rgb_d  = bus.paint_color;
        end
      end

      SYNC1_WAIT, LOAD: begin
        if (bus.rx_valid) begin
          timeout_d = '0;
          if (state_q == SYNC1_WAIT) begin
            if (bus.rx_data == SYNC1) begin
              state_d       = LOAD;
              pixel_count_d = '0;
            end else if (bus.rx_data != SYNC0) begin
              state_d = IDLE;
            end
          end else begin
            bram_we_d     = 1'b1;
            bram_addr_d   = pixel_count_q;
            bram_din_d    = {5'b0, bus.rx_data[2:0]};
            pixel_count_d = pixel_count_q + 19'd1;
            if (pixel_count_q == LAST_PIXEL) begin
              state_d = DONE;
            end
          end
        end else if (timeout_q == TO_LAST) begin
          state_d      = IDLE;
          load_error_d = 1'b1;
          timeout_d    = '0;
        end else begin
          timeout_d = timeout_q + CNT_W'(1);
        end
      end

      DONE: begin
        state_d   = IDLE;
        timeout_d = '0;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign bus.paint_ack   = paint_ack_q;
  assign bus.bram_addr   = bram_addr_q;
  assign bus.bram_din    = bram_din_q;
  assign bus.bram_we     = bram_we_q;
  assign bus.loading     = loading_q;
  assign bus.load_done   = load_done_q;
  assign bus.load_error  = load_error_q;
  assign bus.pixel_count = pixel_count_q;

endmodule

// File: tb/tb_vga_frame_loader.sv
// tb_vga_frame_loader
// Self-checking bench for vga_frame_loader on a reduced 16x8 frame with a
// 100-cycle timeout. Stimulus pushes expected BRAM writes into a queue from
// a protocol-level model; a monitor on the falling edge pops and compares
// every write and counts paint_ack and load_done pulses.
module tb_vga_frame_loader;

  localparam int H_RES = 16;
  localparam int V_RES = 8;
  localparam int NPIX  = H_RES * V_RES;
  localparam int TO    = 100;

  typedef struct packed {
    logic [18:0] addr;
    logic [7:0]  din;
  } wr_t;

  logic clk_50mhz = 1'b0;
  logic reset     = 1'b1;

  vga_frame_loader_if bus ();

  vga_frame_loader #(
    .H_RES(H_RES),
    .V_RES(V_RES),
    .SYNC0(8'hAA),
    .SYNC1(8'h55),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk_50mhz(clk_50mhz),
    .reset(reset),
    .bus(bus)
  );

  always #10 clk_50mhz = ~clk_50mhz;

  wr_t exp_q[$];
  int  vectors     = 0;
  int  miscompares = 0;
  int  ack_seen    = 0;
  int  ack_exp     = 0;
  int  done_seen   = 0;
  int  done_exp    = 0;

  // Protocol-level reference: header matcher plus frame byte counter.
  bit  m_in_frame  = 1'b0;
  bit  m_after_aa  = 1'b0;
  bit  m_err       = 1'b0;
  int  m_count     = 0;

  task automatic check_output(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk_50mhz);
    #1;
  endtask

  function automatic void push_write(input int addr, input int rgb);
    wr_t w;
    w.addr = 19'(addr);
    w.din  = 8'(rgb & 7);
    exp_q.push_back(w);
  endfunction

  function automatic void model_rx(input logic [7:0] b);
    if (m_in_frame) begin
      push_write(m_count, int'(b));
      m_count++;
      if (m_count == NPIX) begin
        m_in_frame = 1'b0;
        done_exp++;
      end
    end else if (m_after_aa) begin
      if (b == 8'h55) begin
        m_in_frame = 1'b1;
        m_after_aa = 1'b0;
        m_count    = 0;
      end else if (b != 8'hAA) begin
        m_after_aa = 1'b0;
      end
    end else if (b == 8'hAA) begin
      m_after_aa = 1'b1;
      m_err      = 1'b0;
    end
  endfunction

  function automatic void model_paint(input int x, input int y, input int c);
    ack_exp++;
    if (x < H_RES && y < V_RES) push_write(y * H_RES + x, c);
  endfunction

  // Sends one UART byte; a pixel byte must show up on the BRAM port and in
  // pixel_count right after the sampling edge.
  task automatic apply_stimulus(input logic [7:0] b, input int gap);
    bit was_pixel;
    was_pixel    = m_in_frame;
    bus.rx_data  = b;
    bus.rx_valid = 1'b1;
    model_rx(b);
    tick();
    bus.rx_valid = 1'b0;
    bus.rx_data  = 8'($urandom);
    if (was_pixel) begin
      check_output("load_we", 32'(bus.bram_we), 32'd1);
      check_output("pixel_count", 32'(bus.pixel_count), 32'(m_count));
    end
    repeat (gap) tick();
  endtask

  // Random pixel bytes (upper bits included); the last one has no gap.
  task automatic send_pixels(input int start, input int count);
    logic [7:0] b;
    for (int k = start; k < start + count; k++) begin
      b = (k == 5) ? 8'hFD : 8'($urandom);
      apply_stimulus(b, (k == start + count - 1) ? 0 : int'($urandom_range(0, 2)));
    end
  endtask

  task automatic paint_once(input int x, input int y, input int c);
    bus.paint_req   = 1'b1;
    bus.paint_x     = 10'(x);
    bus.paint_y     = 10'(y);
    bus.paint_color = 3'(c);
    model_paint(x, y, c);
    tick();
    bus.paint_req = 1'b0;
    check_output("paint_ack", 32'(bus.paint_ack), 32'd1);
    check_output("paint_we_early", 32'(bus.bram_we), 32'd0);
    tick();
    check_output("paint_ack_drop", 32'(bus.paint_ack), 32'd0);
    check_output("paint_we", 32'(bus.bram_we), (x < H_RES && y < V_RES) ? 32'd1 : 32'd0);
    tick();
  endtask

  task automatic check_all_zero(input string tag);
    check_output({tag, "_addr"}, 32'(bus.bram_addr), 32'd0);
    check_output({tag, "_din"}, 32'(bus.bram_din), 32'd0);
    check_output({tag, "_we"}, 32'(bus.bram_we), 32'd0);
    check_output({tag, "_ack"}, 32'(bus.paint_ack), 32'd0);
    check_output({tag, "_loading"}, 32'(bus.loading), 32'd0);
    check_output({tag, "_done"}, 32'(bus.load_done), 32'd0);
    check_output({tag, "_error"}, 32'(bus.load_error), 32'd0);
    check_output({tag, "_count"}, 32'(bus.pixel_count), 32'd0);
  endtask

  // Scoreboard monitor.
  initial begin
    wr_t w;
    forever begin
      @(negedge clk_50mhz);
      if (bus.bram_we === 1'b1) begin
        if (exp_q.size() == 0) begin
          vectors++;
          miscompares++;
          $display("[TB] FAIL unexpected_write: got addr 0x%0h din 0x%0h, expected no write",
                   bus.bram_addr, bus.bram_din);
        end else begin
          w = exp_q.pop_front();
          check_output("bram_addr", 32'(bus.bram_addr), 32'(w.addr));
          check_output("bram_din", 32'(bus.bram_din), 32'(w.din));
        end
      end
      if (bus.paint_ack === 1'b1) ack_seen++;
      if (bus.load_done === 1'b1) done_seen++;
    end
  end

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int waited;
    bus.rx_data     = 8'h00;
    bus.rx_valid    = 1'b0;
    bus.paint_req   = 1'b0;
    bus.paint_x     = 10'd0;
    bus.paint_y     = 10'd0;
    bus.paint_color = 3'd0;

    #25;
    check_all_zero("reset");
    @(negedge clk_50mhz);
    reset = 1'b0;
    tick();

    $display("[TB] full frame load");
    apply_stimulus(8'hAA, 0);
    apply_stimulus(8'h55, 0);
    tick();
    check_output("loading_hdr", 32'(bus.loading), 32'd1);
    send_pixels(0, NPIX);
    check_output("loading_last", 32'(bus.loading), 32'd1);
    bus.rx_data  = 8'hAA;
    bus.rx_valid = 1'b1;
    tick();
    bus.rx_valid = 1'b0;
    check_output("load_done", 32'(bus.load_done), 32'd1);
    check_output("loading_fall", 32'(bus.loading), 32'd0);
    check_output("we_after_last", 32'(bus.bram_we), 32'd0);
    check_output("count_hold", 32'(bus.pixel_count), 32'(NPIX));
    tick();
    check_output("load_done_pulse", 32'(bus.load_done), 32'd0);
    tick();
    check_output("done_byte_dropped", 32'(bus.loading), 32'd0);

    $display("[TB] bad header and header retry");
    apply_stimulus(8'hAA, 1);
    apply_stimulus(8'h12, 3);
    check_output("bad_hdr_loading", 32'(bus.loading), 32'd0);
    check_output("bad_hdr_count", 32'(bus.pixel_count), 32'(NPIX));
    apply_stimulus(8'hAA, 0);
    apply_stimulus(8'hAA, 0);
    apply_stimulus(8'h55, 0);
    send_pixels(0, 10);

    $display("[TB] timeout");
    waited = 0;
    while (bus.load_error !== 1'b1 && waited < 3 * TO) begin
      tick();
      waited++;
    end
    m_in_frame = 1'b0;
    m_after_aa = 1'b0;
    m_err      = 1'b1;
    check_output("timeout_cycles", 32'(waited), 32'(TO));
    check_output("load_error", 32'(bus.load_error), 32'(m_err));
    check_output("timeout_count", 32'(bus.pixel_count), 32'd10);
    tick();
    check_output("timeout_loading", 32'(bus.loading), 32'd0);
    apply_stimulus(8'hAA, 0);
    check_output("error_cleared", 32'(bus.load_error), 32'(m_err));
    apply_stimulus(8'h00, 2);
    check_output("back_idle", 32'(bus.loading), 32'd0);

    $display("[TB] paint");
    paint_once(H_RES - 1, V_RES - 1, 6);
    paint_once(H_RES, 0, 3);
    paint_once(0, V_RES, 7);
    for (int r = 0; r < 12; r++) begin
      int h;
      int x;
      int y;
      int c;
      h = int'($urandom_range(1, 5));
      for (int i = 0; i < h; i++) begin
        x = int'($urandom_range(0, H_RES + 2));
        y = int'($urandom_range(0, V_RES + 1));
        c = int'($urandom_range(0, 7));
        bus.paint_req   = 1'b1;
        bus.paint_x     = 10'(x);
        bus.paint_y     = 10'(y);
        bus.paint_color = 3'(c);
        if (i % 2 == 0) model_paint(x, y, c);
        tick();
      end
      bus.paint_req = 1'b0;
      tick();
      tick();
    end

    $display("[TB] paint held off during load");
    apply_stimulus(8'hAA, 0);
    apply_stimulus(8'h55, 0);
    send_pixels(0, NPIX / 2);
    bus.paint_req   = 1'b1;
    bus.paint_x     = 10'd3;
    bus.paint_y     = 10'd2;
    bus.paint_color = 3'd5;
    send_pixels(NPIX / 2, NPIX - NPIX / 2);
    model_paint(3, 2, 5);
    tick();
    check_output("load_done_2", 32'(bus.load_done), 32'd1);
    check_output("ack_held_off", 32'(bus.paint_ack), 32'd0);
    tick();
    bus.paint_req = 1'b0;
    check_output("ack_after_idle", 32'(bus.paint_ack), 32'd1);
    tick();
    check_output("held_paint_we", 32'(bus.bram_we), 32'd1);
    tick();

    $display("[TB] async reset mid-load");
    apply_stimulus(8'hAA, 0);
    apply_stimulus(8'h55, 0);
    send_pixels(0, 5);
    tick();
    #5;
    reset = 1'b1;
    #1;
    m_in_frame = 1'b0;
    m_after_aa = 1'b0;
    m_err      = 1'b0;
    m_count    = 0;
    check_all_zero("async_reset");
    @(negedge clk_50mhz);
    reset = 1'b0;
    tick();
    apply_stimulus(8'hAA, 0);
    apply_stimulus(8'h55, 0);
    send_pixels(0, NPIX);
    tick();
    check_output("load_done_3", 32'(bus.load_done), 32'd1);

    repeat (4) tick();
    check_output("pending_writes", 32'(exp_q.size()), 32'd0);
    check_output("ack_total", 32'(ack_seen), 32'(ack_exp));
    check_output("done_total", 32'(done_seen), 32'(done_exp));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
